// File: rtl/mac_pkg.sv
// Shared definitions for the MAC_512 accumulator stage.
//   DATA_W   : product / accumulator width (two's complement)
//   acc_state_t : accumulator FSM states
//   SAT_POS / SAT_NEG : clamp values used when MAC_ACC_SATURATE_EN is defined
//   CLA_GRP  : lookahead group size of the adder cell
package mac_pkg;
  localparam int DATA_W  = 32;
  localparam int CLA_GRP = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_t;

  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};
endpackage

// File: rtl/mac_acc_adder.sv
// Combinational carry-lookahead adder (CLA32 cell) with signed overflow.
// 4-bit lookahead groups; group carries chain between groups.
// W must be a multiple of CLA_GRP.
// Ports:
//   a_i, b_i : signed operands
//   sum_o    : a_i + b_i modulo 2^W
//   ovf_o    : signed overflow (carry into MSB != carry out of MSB)
module mac_acc_adder
  import mac_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);
  localparam int NGRP = W / CLA_GRP;

  logic [W-1:0] g, p;
  logic [W:0]   c;

  assign g    = a_i & b_i;
  assign p    = a_i ^ b_i;
  assign c[0] = 1'b0;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    localparam int B = k * CLA_GRP;
    logic grp_g, grp_p;

    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign grp_g  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign grp_p  = &p[B+3:B];
    assign c[B+4] = grp_g | (grp_p & c[B]);
  end

  assign sum_o = p ^ c[W-1:0];
  // Equivalent to "operands share sign and result sign differs".
  assign ovf_o = c[W] ^ c[W-1];
endmodule

// File: rtl/mac_accumulator.sv
// Accumulates exactly LEN signed products per vector and holds the sum on a
// valid/ready output until consumed. Downstream of the MAC_512 multiplier.
// Optional build macro: MAC_ACC_SATURATE_EN -- clamp acc on overflow instead
// of wrapping (ovf is flagged either way).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   clear               : sync abort of the current vector (blocks in_ready)
//   in_valid/in_ready/in_data     : product beat handshake
//   out_valid/out_ready/out_data  : vector sum handshake
//   out_ovf             : sticky overflow for the current vector
//   busy                : accumulating, at least one beat accepted
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int LEN = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  input  logic              out_ready,
  output logic              busy
);
  localparam int CNT_W = $clog2(LEN + 1);

  acc_state_t        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              beat_fire, out_fire, last_beat, add_ovf;
  logic [DATA_W-1:0] addend, sum, sum_sat;

  assign in_ready  = (state_q == ACCUM) & ~clear;
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? acc_q : '0;
  assign out_ovf   = ovf_q;
  assign busy      = (state_q == ACCUM) & (cnt_q != '0);

  assign beat_fire = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign last_beat = (cnt_q == CNT_W'(LEN - 1));

  // Gate the operand so an X on in_data outside a fire never reaches acc.
  assign addend = beat_fire ? in_data : '0;

  mac_acc_adder #(.W(DATA_W)) u_add (
    .a_i   (acc_q),
    .b_i   (addend),
    .sum_o (sum),
    .ovf_o (add_ovf)
  );

`ifdef MAC_ACC_SATURATE_EN
  // Overflow only occurs with same-sign operands, so acc's sign gives direction.
  assign sum_sat = add_ovf ? (acc_q[DATA_W-1] ? SAT_NEG : SAT_POS) : sum;
`else
  assign sum_sat = sum;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (beat_fire) begin
            acc_d = sum_sat;
            ovf_d = ovf_q | add_ovf;
            if (last_beat) begin
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_fire) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            state_d = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
